// File: rtl/semaforo_temporizador.sv
// Timing/sensor front end of the traffic-light controller: conditions the vehicle
// sensor into CAR, times the red phase into TIMEOUT and flags non-one-hot light feedback.
module semaforo_temporizador #(
  parameter int CW             = 8,
  parameter int DEB_CYCLES     = 4,
  parameter int MIN_VERDE      = 8,
  parameter int TEMPO_VERMELHO = 16
) (
  input  logic clk,
  input  logic res,
  input  logic CAR_RAW,
  input  logic VERDE,
  input  logic AMARELO,
  input  logic VERMELHO,
  output logic CAR,
  output logic TIMEOUT,
  output logic ERRO
);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] VERDE_LAST = CW'(MIN_VERDE - 1);
  localparam logic [CW-1:0] RED_LAST   = CW'(TEMPO_VERMELHO - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic          s1, s2;
  logic          car_stable;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] verde_cnt;
  logic [CW-1:0] red_cnt;
  logic          erro;
  logic          one_hot;

  // Two-flop synchroniser for the asynchronous sensor
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= CAR_RAW;
      s2 <= s1;
    end
  end

  // A change is accepted only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      car_stable <= 1'b0;
      deb_cnt    <= '0;
    end else if (s2 == car_stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      car_stable <= s2;
      deb_cnt    <= '0;
    end else begin
      deb_cnt <= deb_cnt + ONE;
    end
  end

  // Phase timers saturate at their last cycle so a stuck phase keeps its flag high
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      verde_cnt <= '0;
      red_cnt   <= '0;
    end else begin
      if (!VERDE)                       verde_cnt <= '0;
      else if (verde_cnt != VERDE_LAST) verde_cnt <= verde_cnt + ONE;
      if (!VERMELHO)                    red_cnt <= '0;
      else if (red_cnt != RED_LAST)     red_cnt <= red_cnt + ONE;
    end
  end

  always_comb begin
    one_hot = 1'b0;
    case ({VERDE, AMARELO, VERMELHO})
      3'b100, 3'b010, 3'b001: one_hot = 1'b1;
      default:                one_hot = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res)          erro <= 1'b0;
    else if (!one_hot) erro <= 1'b1;
  end

  assign CAR     = car_stable & VERDE & (verde_cnt == VERDE_LAST);
  assign TIMEOUT = VERMELHO & (red_cnt == RED_LAST);
  assign ERRO    = erro;

endmodule

// File: tb/tb_semaforo_temporizador.sv
// Directed bench: vector table for debounce/min-green, hand sequences for red timing,
// fault handling and reset behaviour.
module tb_semaforo_temporizador;

  logic clk = 1'b0;
  logic res, CAR_RAW, VERDE, AMARELO, VERMELHO;
  logic CAR, TIMEOUT, ERRO;
  int   checks = 0;
  int   failures = 0;

  semaforo_temporizador #(
    .CW(8), .DEB_CYCLES(4), .MIN_VERDE(8), .TEMPO_VERMELHO(16)
  ) dut (
    .clk(clk), .res(res), .CAR_RAW(CAR_RAW), .VERDE(VERDE), .AMARELO(AMARELO),
    .VERMELHO(VERMELHO), .CAR(CAR), .TIMEOUT(TIMEOUT), .ERRO(ERRO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic raw, g, y, r;
    logic car, to, erro;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lights(input logic g, input logic y, input logic r);
    VERDE = g; AMARELO = y; VERMELHO = r;
  endtask

  function automatic void add_n(input int n, input logic raw, input logic g, input logic y,
                                input logic r, input logic c, input logic t, input logic e);
    vec_t v;
    v.raw = raw; v.g = g; v.y = y; v.r = r; v.car = c; v.to = t; v.erro = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int n, r, k;

    // yellow clears the green timer, then green with no vehicle
    add_n(1, 0, 0, 1, 0, 0, 0, 0);
    add_n(9, 0, 1, 0, 0, 0, 0, 0);
    // held rise: sensor accepted after 6 edges
    add_n(6, 1, 1, 0, 0, 0, 0, 0);
    add_n(2, 1, 1, 0, 0, 1, 0, 0);
    // leaving green drops CAR in the same cycle
    add_n(1, 1, 0, 1, 0, 0, 0, 0);
    // minimum green: CAR only from the 8th green cycle
    add_n(7, 1, 1, 0, 0, 0, 0, 0);
    add_n(2, 1, 1, 0, 0, 1, 0, 0);
    // held fall: same latency
    add_n(6, 0, 1, 0, 0, 1, 0, 0);
    add_n(1, 0, 1, 0, 0, 0, 0, 0);
    // 3-cycle pulse is rejected
    add_n(3, 1, 1, 0, 0, 0, 0, 0);
    add_n(8, 0, 1, 0, 0, 0, 0, 0);
    // glitch train 1,1,0,1,1,1 is rejected
    add_n(2, 1, 1, 0, 0, 0, 0, 0);
    add_n(1, 0, 1, 0, 0, 0, 0, 0);
    add_n(3, 1, 1, 0, 0, 0, 0, 0);
    add_n(8, 0, 1, 0, 0, 0, 0, 0);
    // 4-cycle pulse is just long enough, and its release takes 4 more
    add_n(4, 1, 1, 0, 0, 0, 0, 0);
    add_n(2, 0, 1, 0, 0, 0, 0, 0);
    add_n(4, 0, 1, 0, 0, 1, 0, 0);
    add_n(1, 0, 1, 0, 0, 0, 0, 0);

    // reset with active inputs
    res = 1'b1; CAR_RAW = 1'b1; lights(0, 0, 1);
    #2;
    chk("rst_car", CAR, 1'b0);
    chk("rst_timeout", TIMEOUT, 1'b0);
    chk("rst_erro", ERRO, 1'b0);
    tick(); tick(); tick();
    chk("rst_hold_timeout", TIMEOUT, 1'b0);
    chk("rst_hold_erro", ERRO, 1'b0);
    res = 1'b0; CAR_RAW = 1'b0;

    // red timer starts from zero after release
    for (int c = 0; c < 16; c++) begin
      #1;
      chk($sformatf("red_rel_c%0d", c), TIMEOUT, c == 15);
      tick();
    end

    foreach (vecs[i]) begin
      CAR_RAW = vecs[i].raw;
      lights(vecs[i].g, vecs[i].y, vecs[i].r);
      #1;
      chk($sformatf("vec%0d_car", i), CAR, vecs[i].car);
      chk($sformatf("vec%0d_timeout", i), TIMEOUT, vecs[i].to);
      chk($sformatf("vec%0d_erro", i), ERRO, vecs[i].erro);
      tick();
    end

    // light FSM in the loop: yellow, green until CAR, yellow, red until TIMEOUT
    CAR_RAW = 1'b1; lights(0, 1, 0);
    #1; chk("loop_yellow0_car", CAR, 1'b0);
    tick();
    lights(1, 0, 0);
    n = 0;
    #1;
    while (CAR !== 1'b1 && n < 50) begin tick(); n++; #1; end
    chki("loop_green_len", n + 1, 8);
    tick();
    lights(0, 1, 0);
    #1;
    chk("loop_yellow_car", CAR, 1'b0);
    chk("loop_yellow_timeout", TIMEOUT, 1'b0);
    tick();
    lights(0, 0, 1);
    r = 1;
    #1;
    while (TIMEOUT !== 1'b1 && r < 50) begin tick(); r++; #1; end
    chki("loop_red_len", r, 16);
    tick();
    lights(1, 0, 0);
    #1;
    chk("loop_green_timeout", TIMEOUT, 1'b0);
    chk("loop_erro", ERRO, 1'b0);

    // two lights at once sets the sticky error
    tick();
    lights(1, 1, 0);
    #1; chk("fault_erro_pre", ERRO, 1'b0);
    tick();
    lights(1, 0, 0);
    #1; chk("fault_erro_set", ERRO, 1'b1);
    repeat (5) tick();
    chk("fault_erro_sticky", ERRO, 1'b1);

    // red held past expiry keeps TIMEOUT high
    lights(0, 1, 0); tick();
    lights(0, 0, 1);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 14 || c == 15 || c == 19)
        chk($sformatf("stuck_red_c%0d", c), TIMEOUT, c >= 15);
      tick();
    end
    chk("stuck_red_erro", ERRO, 1'b1);

    // asynchronous reset acts without a clock edge
    res = 1'b1;
    #1;
    chk("async_rst_timeout", TIMEOUT, 1'b0);
    chk("async_rst_erro", ERRO, 1'b0);
    chk("async_rst_car", CAR, 1'b0);
    tick();
    res = 1'b0;

    // reset mid-red restarts the full red duration
    repeat (10) tick();
    #1; chk("midred_pre_timeout", TIMEOUT, 1'b0);
    res = 1'b1;
    tick();
    res = 1'b0;
    k = 0;
    #1;
    while (TIMEOUT !== 1'b1 && k < 40) begin tick(); k++; #1; end
    chki("midred_restart_len", k, 15);

    // all lights off is also a fault
    tick();
    lights(0, 0, 0);
    #1; chk("dark_erro_pre", ERRO, 1'b0);
    tick();
    lights(0, 0, 1);
    #1; chk("dark_erro_set", ERRO, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
